// File: rtl/puf_soc_pkg.sv
// Shared types and default sizes for the PUF response generator.
package puf_soc_pkg;

    localparam int unsigned DEF_CNT_BIT_SIZE = 32;
    localparam int unsigned DEF_RESP_WIDTH   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP_A,
        ST_CAP_B,
        ST_CMP,
        ST_OUT
    } state_e;

endpackage

// File: rtl/puf_cnt_cmp.sv
// Combinational comparison of one RO count pair.
// Reliability mask logic only exists when PUF_RESP_MASK_EN is defined.
module puf_cnt_cmp
    import puf_soc_pkg::*;
#(
    parameter int CNT_BIT_SIZE = DEF_CNT_BIT_SIZE
) (
    input  logic [CNT_BIT_SIZE-1:0] cnt_a,
    input  logic [CNT_BIT_SIZE-1:0] cnt_b,
    input  logic [CNT_BIT_SIZE-1:0] thresh,
    output logic                    gt,
    output logic                    mask
);

    assign gt = (cnt_a > cnt_b);

`ifdef PUF_RESP_MASK_EN
    logic [CNT_BIT_SIZE-1:0] abs_diff;

    // Subtract the smaller from the larger so the difference can never wrap.
    assign abs_diff = gt ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    assign mask     = (abs_diff < thresh);
`else
    logic unused_thresh;

    assign unused_thresh = ^thresh;
    assign mask          = 1'b0;
`endif

endmodule

// File: rtl/puf_resp_gen.sv
// Collects RESP_WIDTH RO count pairs into one response word, bit 0 = first pair.
// Optional reliability masking is enabled with PUF_RESP_MASK_EN.
module puf_resp_gen
    import puf_soc_pkg::*;
#(
    parameter int CNT_BIT_SIZE = DEF_CNT_BIT_SIZE,
    parameter int RESP_WIDTH   = DEF_RESP_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_sys_valid,
    input  logic [CNT_BIT_SIZE-1:0] i_sys_cnt,
    input  logic                    i_sys_cnt_full,
    input  logic [CNT_BIT_SIZE-1:0] i_thresh,
    input  logic                    i_resp_ready,
    output logic [RESP_WIDTH-1:0]   o_resp,
    output logic [RESP_WIDTH-1:0]   o_resp_mask,
    output logic                    o_resp_valid,
    output logic                    o_resp_err,
    output logic                    o_busy
);

    localparam int                IDX_W    = $clog2(RESP_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_WIDTH - 1);

    state_e                  state_q,  state_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [CNT_BIT_SIZE-1:0] cnt_a_q,  cnt_a_d;
    logic [CNT_BIT_SIZE-1:0] cnt_b_q,  cnt_b_d;
    logic                    full_a_q, full_a_d;
    logic                    full_b_q, full_b_d;
    logic [RESP_WIDTH-1:0]   resp_q,   resp_d;
    logic [RESP_WIDTH-1:0]   mask_q,   mask_d;
    logic                    err_q,    err_d;
    logic                    valid_q,  valid_d;
    logic                    busy_q,   busy_d;

    logic cmp_gt;
    logic cmp_mask;

    puf_cnt_cmp #(
        .CNT_BIT_SIZE(CNT_BIT_SIZE)
    ) u_cnt_cmp (
        .cnt_a  (cnt_a_q),
        .cnt_b  (cnt_b_q),
        .thresh (i_thresh),
        .gt     (cmp_gt),
        .mask   (cmp_mask)
    );

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        full_a_d = full_a_q;
        full_b_d = full_b_q;
        resp_d   = resp_q;
        mask_d   = mask_q;
        err_d    = err_q;
        valid_d  = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CAP_A;
                    idx_d   = '0;
                    resp_d  = '0;
                    mask_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CAP_A: begin
                if (i_sys_valid) begin
                    cnt_a_d  = i_sys_cnt;
                    full_a_d = i_sys_cnt_full;
                    state_d  = ST_CAP_B;
                end
            end
            ST_CAP_B: begin
                if (i_sys_valid) begin
                    cnt_b_d  = i_sys_cnt;
                    full_b_d = i_sys_cnt_full;
                    state_d  = ST_CMP;
                end
            end
            ST_CMP: begin
                resp_d[idx_q] = cmp_gt;
                mask_d[idx_q] = cmp_mask;
                if (full_a_q || full_b_q) begin
                    err_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_CAP_A;
                end
            end
            ST_OUT: begin
                // Word stays on the outputs after the handshake until the next start.
                if (i_resp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so an aborted word leaves nothing behind.
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            resp_q   <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
            resp_q   <= resp_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign o_resp       = resp_q;
    assign o_resp_mask  = mask_q;
    assign o_resp_valid = valid_q;
    assign o_resp_err   = err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Scoreboard bench for puf_resp_gen: a driver pushes model results, a monitor pops on each new word.
// Mask expectations follow PUF_RESP_MASK_EN as compiled.
module tb_puf_resp_gen;

    localparam int CW = 32;
    localparam int RW = 4;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_sys_valid = 1'b0;
    logic [CW-1:0] i_sys_cnt = '0;
    logic          i_sys_cnt_full = 1'b0;
    logic [CW-1:0] i_thresh = '0;
    logic          i_resp_ready = 1'b0;
    logic [RW-1:0] o_resp;
    logic [RW-1:0] o_resp_mask;
    logic          o_resp_valid;
    logic          o_resp_err;
    logic          o_busy;

    puf_resp_gen #(
        .CNT_BIT_SIZE (CW),
        .RESP_WIDTH   (RW)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_sys_valid    (i_sys_valid),
        .i_sys_cnt      (i_sys_cnt),
        .i_sys_cnt_full (i_sys_cnt_full),
        .i_thresh       (i_thresh),
        .i_resp_ready   (i_resp_ready),
        .o_resp         (o_resp),
        .o_resp_mask    (o_resp_mask),
        .o_resp_valid   (o_resp_valid),
        .o_resp_err     (o_resp_err),
        .o_busy         (o_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] resp;
        logic [RW-1:0] mask;
        logic          err;
        int unsigned   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;

    logic [CW-1:0] pa[RW];
    logic [CW-1:0] pb[RW];
    logic          fa[RW];
    logic          fb[RW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: each pair gives A>B, masked when the distance is under the threshold.
    function automatic exp_t model(input int unsigned lat_cyc);
        exp_t e;
        longint unsigned a, b;
        e.resp = '0;
        e.mask = '0;
        e.err  = 1'b0;
        e.cyc  = lat_cyc;
        for (int i = 0; i < RW; i++) begin
            a = longint'(pa[i]);
            b = longint'(pb[i]);
            e.resp[i] = (a > b);
`ifdef PUF_RESP_MASK_EN
            begin
                longint unsigned dist;
                dist = (a > b) ? (a - b) : (b - a);
                e.mask[i] = (dist < longint'(i_thresh));
            end
`endif
            e.err = e.err | fa[i] | fb[i];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic send_cnt(input logic [CW-1:0] c, input logic f);
        i_sys_valid    = 1'b1;
        i_sys_cnt      = c;
        i_sys_cnt_full = f;
        tick();
        i_sys_valid    = 1'b0;
        i_sys_cnt      = $urandom;
        i_sys_cnt_full = 1'($urandom_range(0, 1));
    endtask

    task automatic set_pair(input int i, input logic [CW-1:0] a, input logic [CW-1:0] b,
                            input logic fla, input logic flb);
        pa[i] = a;
        pb[i] = b;
        fa[i] = fla;
        fb[i] = flb;
    endtask

    // junk: inject inputs that must be ignored; abort_at: pair index at which reset hits.
    task automatic run_word(input int stall, input bit junk, input int abort_at);
        int unsigned n;
        int          k;
        n = 0;
        if (junk) begin
            i_sys_valid = 1'b1;
            i_sys_cnt   = $urandom;
            tick();
            i_start = 1'b1;
            tick();
            i_start     = 1'b0;
            i_sys_valid = 1'b0;
        end else begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        check("start_busy", 64'(o_busy), 64'(1));
        check("start_clear", 64'({o_resp_valid, o_resp_err, o_resp, o_resp_mask}), 64'(0));

        for (int i = 0; i < RW; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                tick();
                check("reset_clear", 64'({o_busy, o_resp_valid, o_resp_err, o_resp, o_resp_mask}), 64'(0));
                rst_n = 1'b1;
                tick();
                check("reset_idle_busy", 64'(o_busy), 64'(0));
                return;
            end
            send_cnt(pa[i], fa[i]);
            if (junk && i == 0) begin
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
            n = cyc;
            send_cnt(pb[i], fb[i]);
            if (junk) begin
                i_sys_valid    = 1'b1;
                i_sys_cnt      = $urandom;
                i_sys_cnt_full = 1'b1;
                tick();
                i_sys_valid    = 1'b0;
                i_sys_cnt_full = 1'b0;
            end else begin
                tick();
            end
            if (i < RW - 1) repeat ($urandom_range(0, 2)) tick();
        end

        exp_q.push_back(model(n + 2));

        k = 0;
        while (!o_resp_valid && k < 8) begin
            tick();
            k++;
        end
        check("valid_seen", 64'(o_resp_valid), 64'(1));
        repeat (stall) tick();
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
    endtask

    // Monitor: new word -> compare with scoreboard; held word -> must stay stable.
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [RW-1:0] hold_resp = '0;
    logic [RW-1:0] hold_mask = '0;
    logic          hold_err = 1'b0;
    exp_t          mon_e;

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (o_resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(o_resp_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp", 64'(o_resp), 64'(mon_e.resp));
                    check("mask", 64'(o_resp_mask), 64'(mon_e.mask));
                    check("err", 64'(o_resp_err), 64'(mon_e.err));
                    check("latency_cyc", 64'(cyc), 64'(mon_e.cyc));
                end
                hold_resp = o_resp;
                hold_mask = o_resp_mask;
                hold_err  = o_resp_err;
            end else if (o_resp_valid) begin
                check("hold_stable", 64'({o_resp, o_resp_mask, o_resp_err}),
                      64'({hold_resp, hold_mask, hold_err}));
            end
            if (!o_resp_valid && prev_valid && prev_ready) begin
                check("post_idle_busy", 64'(o_busy), 64'(0));
                check("post_resp_held", 64'(o_resp), 64'(hold_resp));
            end
            prev_valid = o_resp_valid;
            prev_ready = i_resp_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] a;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_resp", 64'(o_resp), 64'(0));
        check("rst_mask", 64'(o_resp_mask), 64'(0));
        check("rst_valid", 64'(o_resp_valid), 64'(0));
        check("rst_err", 64'(o_resp_err), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        rst_n = 1'b1;
        tick();

        i_thresh = 5;
        set_pair(0, 100, 90, 0, 0);
        set_pair(1, 50, 60, 0, 0);
        set_pair(2, 7, 7, 0, 0);
        set_pair(3, 32'hFFFF_FFFF, 0, 0, 0);
        run_word(2, 1'b0, -1);

        set_pair(0, 100, 98, 0, 0);
        set_pair(1, 10, 30, 0, 0);
        set_pair(2, 40, 40, 0, 0);
        set_pair(3, 9, 1, 0, 0);
        run_word(1, 1'b0, -1);

        set_pair(0, 200, 100, 1, 0);
        set_pair(1, 3, 4, 0, 0);
        set_pair(2, 8, 2, 0, 0);
        set_pair(3, 0, 0, 0, 0);
        run_word(0, 1'b0, -1);

        set_pair(0, 5, 1, 0, 0);
        set_pair(1, 1, 5, 0, 0);
        set_pair(2, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
        set_pair(3, 12, 13, 0, 0);
        run_word(10, 1'b1, -1);

        set_pair(0, 77, 33, 0, 1);
        set_pair(1, 33, 77, 0, 0);
        set_pair(2, 1, 0, 1, 0);
        set_pair(3, 0, 1, 0, 0);
        run_word(0, 1'b0, 2);
        run_word(1, 1'b0, -1);

        for (int w = 0; w < 20; w++) begin
            i_thresh = CW'($urandom_range(0, 40));
            for (int i = 0; i < RW; i++) begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0:       pb[i] = a;
                    1:       pb[i] = a + CW'($urandom_range(0, 30));
                    2:       pb[i] = a - CW'($urandom_range(0, 30));
                    default: pb[i] = $urandom;
                endcase
                pa[i] = a;
                fa[i] = ($urandom_range(0, 7) == 0);
                fb[i] = ($urandom_range(0, 7) == 0);
            end
            run_word($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        repeat (4) tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
